indexed_queue: RTL

INDEXED_QUEUE -- requirements
Module: indexed_queue

---
 rtl/indexed_queue_pkg.sv | 22 ++
 rtl/iq_storage.sv | 32 +++
 rtl/indexed_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/indexed_queue_pkg.sv
// indexed_queue_pkg: shared defaults and queue op encoding.
// Imported by indexed_queue and iq_storage.
package indexed_queue_pkg;

  localparam int IQ_DATA_W = 32;
  localparam int IQ_DEPTH  = 16;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    PUSHPOP = 2'b11
  } iq_op_e;

  function automatic iq_op_e iq_op(
    input logic push,
    input logic pop
  );
    return iq_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/iq_storage.sv
// iq_storage: DEPTH x DATA_W array, one write port,
// two asynchronous read ports (head and indexed).
module iq_storage
  import indexed_queue_pkg::*;
#(
  parameter int DATA_W = IQ_DATA_W,
  parameter int DEPTH  = IQ_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [PTR_W-1:0]  idx_addr,
  output logic [DATA_W-1:0] idx_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign head_data = mem[head_addr];
  assign idx_data  = mem[idx_addr];

endmodule

// File: rtl/indexed_queue.sv
// indexed_queue: circular FIFO with registered indexed read.
// Optional sticky err port: define INDEXED_QUEUE_ERR_EN.
module indexed_queue
  import indexed_queue_pkg::*;
#(
  parameter int DATA_W = IQ_DATA_W,
  parameter int DEPTH  = IQ_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push_en,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_en,
  output logic [DATA_W-1:0] pop_data,
  input  logic              rd_en,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  q_size,
  output logic              full,
  output logic              empty
`ifdef INDEXED_QUEUE_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  idx_addr;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] idx_data;
  logic              push_acc;
  logic              pop_acc;
  logic              rd_hit;
  logic              wr_en;
  iq_op_e            op;

  assign full  = (q_size == CNT_W'(DEPTH));
  assign empty = (q_size == '0);

  // A pop frees a slot in the same cycle, so a full queue still accepts.
  assign push_ready = !full || pop_en;
  assign push_acc   = push_en && push_ready;
  assign pop_acc    = pop_en && !empty;
  assign op         = iq_op(push_acc, pop_acc);

  assign wr_en    = push_acc && !clear;
  assign rd_hit   = (rd_idx < q_size);
  assign idx_addr = head + rd_idx[PTR_W-1:0];
  assign pop_data = empty ? '0 : head_data;

  iq_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_storage (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (tail),
    .wr_data   (push_data),
    .head_addr (head),
    .head_data (head_data),
    .idx_addr  (idx_addr),
    .idx_data  (idx_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      q_size <= '0;
    end else if (clear) begin
      head   <= '0;
      tail   <= '0;
      q_size <= '0;
    end else begin
      if (push_acc) tail <= tail + PTR_W'(1);
      if (pop_acc)  head <= head + PTR_W'(1);
      unique case (op)
        PUSH:    q_size <= q_size + CNT_W'(1);
        POP:     q_size <= q_size - CNT_W'(1);
        default: q_size <= q_size;
      endcase
    end
  end

  // Read samples pre-edge contents, so clear does not affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_hit ? idx_data : '0;
      end
    end
  end

`ifdef INDEXED_QUEUE_ERR_EN
  logic err_hit;

  assign err_hit = (push_en && !push_ready)
                || (pop_en && empty)
                || (rd_en && !rd_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (err_hit) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
